// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the pierogi execute-stage ALU: opcode encodings,
// the default datapath width, and signed-overflow helpers used by alu_comb.
// No ports (package).
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_SHW   = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_NOT = 4'b0011;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0101;
    localparam logic [3:0] ALU_SLT = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b1010;
    localparam logic [3:0] ALU_SRL = 4'b1011;
    localparam logic [3:0] ALU_LUI = 4'b1101;

    // Addition overflows when both operands share a sign the result lacks.
    function automatic logic addOvf(input logic aMsb, input logic bMsb, input logic rMsb);
        return (aMsb == bMsb) && (rMsb != aMsb);
    endfunction

    // Subtraction overflows when the operands differ in sign and the result
    // sign no longer matches the minuend.
    function automatic logic subOvf(input logic aMsb, input logic bMsb, input logic rMsb);
        return (aMsb != bMsb) && (rMsb != aMsb);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// ---------------------------------------------------------------------------
// alu_comb
// Purely combinational operation mux of the execute-stage ALU.
// Ports:
//   aluOp  - 4-bit operation select (encodings in alu_pkg)
//   busA   - operand A
//   busB   - operand B / shift amount / immediate
//   result - selected result (0 for unassigned opcodes)
//   ovf    - signed overflow, only meaningful for ADD/SUB, else 0
// ---------------------------------------------------------------------------
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SHW   = ALU_SHW
) (
    input  logic [3:0]       aluOp,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    logic signed [WIDTH-1:0] opA;
    logic signed [WIDTH-1:0] opB;
    logic        [WIDTH-1:0] sum;
    logic        [WIDTH-1:0] diff;
    logic        [SHW-1:0]   shAmt;

    assign opA   = busA;
    assign opB   = busB;
    assign sum   = busA + busB;
    assign diff  = busA - busB;
    // Only the low SHW bits of B select the shift distance.
    assign shAmt = busB[SHW-1:0];

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (aluOp)
            ALU_AND: result = busA & busB;
            ALU_OR:  result = busA | busB;
            ALU_XOR: result = busA ^ busB;
            ALU_NOT: result = ~busA;
            ALU_ADD: begin
                result = sum;
                ovf    = addOvf(busA[WIDTH-1], busB[WIDTH-1], sum[WIDTH-1]);
            end
            ALU_SUB: begin
                result = diff;
                ovf    = subOvf(busA[WIDTH-1], busB[WIDTH-1], diff[WIDTH-1]);
            end
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, (opA < opB)};
            ALU_SLL: result = busA << shAmt;
            ALU_SRL: result = busA >> shAmt;
            ALU_LUI: result = {busB[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default: begin
                result = '0;
                ovf    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_reg.sv
// ---------------------------------------------------------------------------
// alu_reg
// Execute-stage ALU with a registered result (1-cycle latency).
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - asynchronous active-low reset
//   in_valid  - opcode/operands valid this cycle
//   AluOp     - operation select
//   busA      - operand A
//   busB      - operand B / shift amount / immediate
//   out_valid - outBus/flags carry a result captured on the previous edge
//   outBus    - registered result
//   zero      - registered (result == 0)
//   ovf       - registered signed overflow (ADD/SUB only)
// Outputs hold their last value while in_valid is low; only out_valid drops.
// ---------------------------------------------------------------------------
module alu_reg
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SHW   = ALU_SHW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       AluOp,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    output logic             out_valid,
    output logic [WIDTH-1:0] outBus,
    output logic             zero,
    output logic             ovf
);

    logic [WIDTH-1:0] result_p0;
    logic             ovf_p0;
    logic             zero_p0;

    alu_comb #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) uComb (
        .aluOp  (AluOp),
        .busA   (busA),
        .busB   (busB),
        .result (result_p0),
        .ovf    (ovf_p0)
    );

    assign zero_p0 = (result_p0 == '0);

    // Stage p0 -> p1: output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            outBus    <= '0;
            zero      <= 1'b1;
            ovf       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                outBus <= result_p0;
                zero   <= zero_p0;
                ovf    <= ovf_p0;
            end
        end
    end

endmodule

// File: tb/tb_alu_reg.sv
module tb_alu_reg;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [3:0]   AluOp;
    logic [W-1:0] busA;
    logic [W-1:0] busB;
    logic         out_valid;
    logic [W-1:0] outBus;
    logic         zero;
    logic         ovf;

    int nChecks = 0;
    int nFail   = 0;

    // Behavioural expectation of the registered outputs.
    logic [W-1:0] expOut;
    logic         expZero;
    logic         expOvf;
    logic         expValid;

    alu_reg dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .AluOp     (AluOp),
        .busA      (busA),
        .busB      (busB),
        .out_valid (out_valid),
        .outBus    (outBus),
        .zero      (zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         v;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Reference computed from the arithmetic definitions with wide signed math.
    function automatic void refModel(input logic [3:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b,
                                     output logic [W-1:0] res, output logic v);
        longint sa, sb, s;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        v   = 1'b0;
        res = '0;
        case (op)
            4'd0:  res = a & b;
            4'd1:  res = a | b;
            4'd2:  res = a ^ b;
            4'd3:  res = ~a;
            4'd4: begin
                s   = sa + sb;
                res = s[W-1:0];
                v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd5: begin
                s   = sa - sb;
                res = s[W-1:0];
                v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd6:  res = (sa < sb) ? 32'd1 : 32'd0;
            4'd10: res = a << (b % 32);
            4'd11: res = a >> (b % 32);
            4'd13: res = (b % 32'd65536) * 32'd65536;
            default: res = '0;
        endcase
    endfunction

    // Drive one cycle of inputs, let the edge capture, check against the model.
    task automatic step(input logic vld, input logic [3:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [W-1:0] r;
        logic         v;
        @(negedge clk);
        in_valid = vld;
        AluOp    = op;
        busA     = a;
        busB     = b;
        @(negedge clk);
        if (vld) begin
            refModel(op, a, b, r, v);
            expOut  = r;
            expZero = (r == '0);
            expOvf  = v;
        end
        expValid = vld;
        check({tag, ".outBus"},    outBus,             expOut);
        check({tag, ".zero"},      {31'd0, zero},      {31'd0, expZero});
        check({tag, ".ovf"},       {31'd0, ovf},       {31'd0, expOvf});
        check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, expValid});
    endtask

    task automatic checkReset(input string tag);
        check({tag, ".outBus"},    outBus,             32'd0);
        check({tag, ".zero"},      {31'd0, zero},      32'd1);
        check({tag, ".ovf"},       {31'd0, ovf},       32'd0);
        check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [W-1:0] edgeVals[8];
        logic [W-1:0] ra, rb;
        logic [3:0]   rop;
        logic         rv;

        vecs.push_back('{"and",    4'b0000, 32'd4,          32'd3,          32'd0,          1'b1, 1'b0});
        vecs.push_back('{"or",     4'b0001, 32'd4,          32'd3,          32'd7,          1'b0, 1'b0});
        vecs.push_back('{"xor",    4'b0010, 32'd5,          32'd3,          32'd6,          1'b0, 1'b0});
        vecs.push_back('{"not",    4'b0011, 32'd1,          32'd99,         32'hFFFFFFFE,   1'b0, 1'b0});
        vecs.push_back('{"add",    4'b0100, 32'd10,         32'd15,         32'd25,         1'b0, 1'b0});
        vecs.push_back('{"addovf", 4'b0100, 32'h7FFFFFFF,   32'd1,          32'h80000000,   1'b0, 1'b1});
        vecs.push_back('{"sub",    4'b0101, 32'd20,         32'd5,          32'd15,         1'b0, 1'b0});
        vecs.push_back('{"subovf", 4'b0101, 32'h80000000,   32'd1,          32'h7FFFFFFF,   1'b0, 1'b1});
        vecs.push_back('{"slt1",   4'b0110, 32'd5,          32'd10,         32'd1,          1'b0, 1'b0});
        vecs.push_back('{"slt0",   4'b0110, 32'd15,         32'd10,         32'd0,          1'b1, 1'b0});
        vecs.push_back('{"sltneg", 4'b0110, 32'hFFFFFFFF,   32'd1,          32'd1,          1'b0, 1'b0});
        vecs.push_back('{"slteq",  4'b0110, 32'd7,          32'd7,          32'd0,          1'b1, 1'b0});
        vecs.push_back('{"sll",    4'b1010, 32'd1,          32'd2,          32'd4,          1'b0, 1'b0});
        vecs.push_back('{"srl",    4'b1011, 32'd8,          32'd3,          32'd1,          1'b0, 1'b0});
        vecs.push_back('{"srl31",  4'b1011, 32'h80000000,   32'd31,         32'd1,          1'b0, 1'b0});
        vecs.push_back('{"sllhi",  4'b1010, 32'h00000123,   32'h22,         32'h0000048C,   1'b0, 1'b0});
        vecs.push_back('{"sll0",   4'b1010, 32'hDEADBEEF,   32'h0,          32'hDEADBEEF,   1'b0, 1'b0});
        vecs.push_back('{"lui1",   4'b1101, 32'd77,         32'd1,          32'd65536,      1'b0, 1'b0});
        vecs.push_back('{"lui2",   4'b1101, 32'd0,          32'hABCD1234,   32'h12340000,   1'b0, 1'b0});
        vecs.push_back('{"illeg",  4'b1111, 32'd123,        32'd456,        32'd0,          1'b1, 1'b0});
        vecs.push_back('{"illeg7", 4'b0111, 32'hFFFFFFFF,   32'h1,          32'd0,          1'b1, 1'b0});

        // Reset held while clocking
        rst_n    = 1'b0;
        in_valid = 1'b0;
        AluOp    = 4'd0;
        busA     = '0;
        busB     = '0;
        repeat (3) @(negedge clk);
        checkReset("rst_hold");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkReset("rst_release");
        expOut = '0; expZero = 1'b1; expOvf = 1'b0; expValid = 1'b0;

        // Directed table, each checked against its hand-derived constants
        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid = 1'b1;
            AluOp    = vecs[i].op;
            busA     = vecs[i].a;
            busB     = vecs[i].b;
            @(negedge clk);
            in_valid = 1'b0;
            check({vecs[i].name, ".outBus"},    outBus,             vecs[i].res);
            check({vecs[i].name, ".zero"},      {31'd0, zero},      {31'd0, vecs[i].z});
            check({vecs[i].name, ".ovf"},       {31'd0, ovf},       {31'd0, vecs[i].v});
            check({vecs[i].name, ".out_valid"}, {31'd0, out_valid}, 32'd1);
        end

        // Hold: drop in_valid with different inputs, result must not move
        step(1'b1, 4'b0100, 32'd100, 32'd23, "hold_load");
        @(negedge clk);
        in_valid = 1'b0;
        AluOp    = 4'b0011;
        busA     = 32'h0;
        busB     = 32'h0;
        @(negedge clk);
        check("hold.outBus",    outBus,             32'd123);
        check("hold.out_valid", {31'd0, out_valid}, 32'd0);
        check("hold.zero",      {31'd0, zero},      32'd0);

        // Back-to-back issue, then random traffic against the model
        step(1'b1, 4'b0001, 32'hF0, 32'h0F, "b2b0");
        step(1'b1, 4'b0101, 32'd0,  32'd1,  "b2b1");
        step(1'b1, 4'b0110, 32'h80000000, 32'h7FFFFFFF, "b2b2");

        edgeVals = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF,
                     32'h80000000, 32'h0000FFFF, 32'hFFFF0000, 32'h55555555};
        for (int n = 0; n < 300; n++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 7)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 7)] : $urandom;
            rv  = ($urandom_range(0, 4) != 0);
            step(rv, rop, ra, rb, "rand");
        end

        // Asynchronous reset between edges clears outputs without a clock
        step(1'b1, 4'b0100, 32'h7FFFFFFF, 32'd1, "pre_rst");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("async_rst");
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        expOut = '0; expZero = 1'b1; expOvf = 1'b0; expValid = 1'b0;
        step(1'b1, 4'b0000, 32'hFF, 32'h0F, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
